ws2812_stream_tx: RTL and testbench
===================================

WS2812_STREAM_TX -- requirements
Module: ws2812_stream_tx

Interface
REQ-001 SHALL have parameter CHANNELS, default 4: number of independent WS2812 output lines, range 1..8.
REQ-002 SHALL have parameter DEPTH, default 8: input FIFO entries, power of two, minimum 2.
REQ-003 SHALL have parameters T0H_CYC 8, T1H_CYC 16, TBIT_CYC 25 and TRESET_CYC 1000: clock-cycle timings (20 MHz basis), constrained T0H_CYC < T1H_CYC < TBIT_CYC.
REQ-004 SHALL have port clk, input, 1: sole clock, rising edge.
REQ-005 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-006 SHALL have port in_data, input, 8: GRB byte, MSB transmitted first.
REQ-007 SHALL have port in_chan, input, CW = max(1, clog2(CHANNELS)): target channel, honoured only on the first byte of a frame.
REQ-008 SHALL have port in_last, input, 1: marks the final byte of a frame.
REQ-009 SHALL have ports in_valid (input, 1) and in_ready (output, 1): byte accepted on a rising edge where both are high.
REQ-010 SHALL have port dout, output, CHANNELS: WS2812 data lines.
REQ-011 SHALL have port busy, output, 1: high whenever the FSM is not IDLE or the FIFO is non-empty.
REQ-012 SHALL have port underrun, output, 1: sticky error flag (see Configuration).

Function
REQ-013 SHALL buffer {in_chan, in_last, in_data} in a DEPTH-entry FIFO; in_ready = not full; a push while full is ignored; a simultaneous pop and push when full does not raise in_ready in that cycle.
REQ-014 SHALL implement FSM states IDLE, LOAD, HIGH, LOW and LATCH.
REQ-015 IDLE: all dout low; when the FIFO is non-empty, pop the entry, latch its channel as the active channel, and go to LOAD.
REQ-016 LOAD: load the byte into a shift register, set the bit counter to 7, and go to HIGH in the next cycle.
REQ-017 HIGH: dout[active] high for T1H_CYC cycles if the current bit is 1, otherwise T0H_CYC; then go to LOW.
REQ-018 LOW: dout[active] low until the bit period totals exactly TBIT_CYC cycles; then take the next bit (go to HIGH), or end the byte.
REQ-019 At end of byte, if the byte was marked last: go to LATCH. Otherwise, if the FIFO is non-empty: pop the entry and go to LOAD, ignoring the popped channel. Otherwise: remain in LOW with the line low (stall).
REQ-020 Back-to-back bytes SHALL add no dead time beyond the LOAD cycle, which is counted inside the previous bit's low phase.
REQ-021 LATCH: all dout low for exactly TRESET_CYC cycles, then go to IDLE.
REQ-022 Inactive channels SHALL be low at all times.
REQ-023 Latency: with the FSM IDLE and the FIFO empty, dout[in_chan] SHALL rise exactly 3 cycles after the accepting edge.
REQ-024 Cycle counters SHALL be sized to hold TRESET_CYC and SHALL never wrap.

Reset
REQ-025 While rst is high: FIFO emptied, FSM forced to IDLE, counters zeroed, dout = 0, busy = 0, in_ready = 0, underrun = 0.
REQ-026 After reset deassertion: in_ready = 1 from the first edge.
REQ-027 Reset asserted mid-bit SHALL force dout low immediately (asynchronously) and discard the partial frame.

Configuration
REQ-028 Macro WS2812_UNDERRUN_ABORT_EN.
REQ-029 With the macro defined: a stall (REQ-019) lasting TRESET_CYC cycles SHALL abort the frame, set underrun, and go to IDLE. underrun clears on the next frame start (IDLE pop). Any subsequent bytes up to and including the next last-marked byte start a new frame.
REQ-030 Without the macro defined: a stall persists indefinitely, and underrun is tied to 0.

Verification
REQ-031 Reset, then push 0xA5 as last on chan 2 -> dout[2] pattern H16/L9, H8/L17, H16/L9, H8/L17, H8/L17, H16/L9, H8/L17, H16/L9; then 1000 cycles low; busy drops; other dout stay 0.
REQ-032 Push 3 bytes back-to-back, last on the third -> 24 contiguous 25-cycle bit periods with no gaps, followed by a single LATCH.
REQ-033 Hold in_valid high with the output stalled -> in_ready falls after exactly DEPTH accepted bytes; no byte lost or duplicated.
REQ-034 Frame on chan 1 with later bytes carrying chan 3 -> the whole frame appears on dout[1]; the next frame after LATCH on chan 3 appears on dout[3].
REQ-035 Push one non-last byte, then none -> with the macro, underrun = 1 after 1000 stall cycles and FSM in IDLE; without the macro, busy stays 1 and underrun stays 0.
REQ-036 Assert rst during the HIGH phase of bit 3 -> dout = 0 in the same cycle; after release, no residual output and in_ready = 1.

Source files
------------

// File: rtl/ws2812_stream_tx.sv
// WS2812 serializer: a byte FIFO feeds one of CHANNELS data lines, one frame at a time.
// Optional macro WS2812_UNDERRUN_ABORT_EN aborts a frame whose data stalls for TRESET_CYC cycles.
module ws2812_stream_tx #(
    parameter int CHANNELS   = 4,
    parameter int DEPTH      = 8,
    parameter int T0H_CYC    = 8,
    parameter int T1H_CYC    = 16,
    parameter int TBIT_CYC   = 25,
    parameter int TRESET_CYC = 1000,
    localparam int CW        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [7:0]          in_data,
    input  logic [CW-1:0]       in_chan,
    input  logic                in_last,
    input  logic                in_valid,
    output logic                in_ready,
    output logic [CHANNELS-1:0] dout,
    output logic                busy,
    output logic                underrun
);
    localparam int AW   = $clog2(DEPTH);
    localparam int EW   = CW + 9;
    localparam int TMAX = (TRESET_CYC > TBIT_CYC) ? TRESET_CYC : TBIT_CYC;
    localparam int TW   = $clog2(TMAX + 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        HIGH  = 3'd2,
        LOW   = 3'd3,
        LATCH = 3'd4
    } state_t;

    logic [EW-1:0]       mem_r [DEPTH];
    logic [AW:0]         wr_ptr_r, rd_ptr_r;
    logic [AW:0]         count_s, count_next_s;
    logic                push_s, pop_s, empty_s, load_point_s;
    logic [EW-1:0]       head_s;
    logic [TW-1:0]       th_s;
    logic [CHANNELS-1:0] sel_s;

    state_t              state_r;
    logic [TW-1:0]       tcnt_r;
    logic [2:0]          bit_idx_r;
    logic [7:0]          shift_r, data_r;
    logic                last_r;
    logic [CW-1:0]       active_r;
    logic [CHANNELS-1:0] dout_r;
    logic                busy_r, in_ready_r;
`ifdef WS2812_UNDERRUN_ABORT_EN
    logic [TW-1:0]       stall_r;
    logic                underrun_r;
`endif

    assign count_s      = wr_ptr_r - rd_ptr_r;
    assign empty_s      = (count_s == (AW+1)'(0));
    assign head_s       = mem_r[rd_ptr_r[AW-1:0]];
    assign push_s       = in_valid && in_ready_r;
    // The next byte is fetched one cycle before the bit period ends so LOAD fills that slot.
    assign load_point_s = (state_r == LOW) && (bit_idx_r == 3'd0) && !last_r
                          && (tcnt_r == TW'(TBIT_CYC - 2));
    assign pop_s        = !empty_s && ((state_r == IDLE) || load_point_s);
    assign count_next_s = count_s + (AW+1)'(push_s) - (AW+1)'(pop_s);
    assign th_s         = shift_r[7] ? TW'(T1H_CYC - 1) : TW'(T0H_CYC - 1);
    assign sel_s        = CHANNELS'(1'b1) << active_r;

    assign in_ready = in_ready_r;
    assign dout     = dout_r;
    assign busy     = busy_r;
`ifdef WS2812_UNDERRUN_ABORT_EN
    assign underrun = underrun_r;
`else
    assign underrun = 1'b0;
`endif

    // FIFO storage, written on every accepted byte
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= {in_chan, in_last, in_data};
        end
    end

    // FIFO pointers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
        end else begin
            if (push_s) wr_ptr_r <= wr_ptr_r + (AW+1)'(1);
            if (pop_s)  rd_ptr_r <= rd_ptr_r + (AW+1)'(1);
        end
    end

    // Bit-timing FSM with registered line, busy and ready outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= IDLE;
            tcnt_r     <= '0;
            bit_idx_r  <= 3'd0;
            shift_r    <= 8'd0;
            data_r     <= 8'd0;
            last_r     <= 1'b0;
            active_r   <= '0;
            dout_r     <= '0;
            busy_r     <= 1'b0;
            in_ready_r <= 1'b0;
`ifdef WS2812_UNDERRUN_ABORT_EN
            stall_r    <= '0;
            underrun_r <= 1'b0;
`endif
        end else begin
            in_ready_r <= (count_next_s != (AW+1)'(DEPTH));
            dout_r     <= (state_r == HIGH) ? sel_s : '0;
            busy_r     <= (state_r != IDLE) || (count_next_s != (AW+1)'(0));
            case (state_r)
                IDLE: begin
                    tcnt_r <= '0;
                    if (!empty_s) begin
                        active_r <= head_s[EW-1 -: CW];
                        last_r   <= head_s[8];
                        data_r   <= head_s[7:0];
                        busy_r   <= 1'b1;
                        state_r  <= LOAD;
`ifdef WS2812_UNDERRUN_ABORT_EN
                        underrun_r <= 1'b0;
`endif
                    end else begin
                        state_r <= IDLE;
                    end
                end
                LOAD: begin
                    shift_r   <= data_r;
                    bit_idx_r <= 3'd7;
                    tcnt_r    <= '0;
                    state_r   <= HIGH;
                end
                HIGH: begin
                    tcnt_r <= tcnt_r + TW'(1);
                    if (tcnt_r == th_s) state_r <= LOW;
                    else                state_r <= HIGH;
                end
                LOW: begin
                    if (load_point_s) begin
                        if (!empty_s) begin
                            last_r  <= head_s[8];
                            data_r  <= head_s[7:0];
                            state_r <= LOAD;
`ifdef WS2812_UNDERRUN_ABORT_EN
                            stall_r <= '0;
                        end else if (stall_r == TW'(TRESET_CYC - 1)) begin
                            stall_r    <= '0;
                            underrun_r <= 1'b1;
                            busy_r     <= (count_next_s != (AW+1)'(0));
                            state_r    <= IDLE;
                        end else begin
                            stall_r <= stall_r + TW'(1);
                        end
`else
                        end else begin
                            state_r <= LOW;
                        end
`endif
                    end else if (tcnt_r == TW'(TBIT_CYC - 1)) begin
                        tcnt_r <= '0;
                        if (bit_idx_r != 3'd0) begin
                            bit_idx_r <= bit_idx_r - 3'd1;
                            shift_r   <= {shift_r[6:0], 1'b0};
                            state_r   <= HIGH;
                        end else begin
                            state_r <= LATCH;
                        end
                    end else begin
                        tcnt_r <= tcnt_r + TW'(1);
                    end
                end
                LATCH: begin
                    if (tcnt_r == TW'(TRESET_CYC - 1)) begin
                        tcnt_r  <= '0;
                        busy_r  <= (count_next_s != (AW+1)'(0));
                        state_r <= IDLE;
                    end else begin
                        tcnt_r <= tcnt_r + TW'(1);
                    end
                end
                default: state_r <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ws2812_stream_tx.sv
// Self-checking bench for ws2812_stream_tx: vector table, corner sequences and a waveform model.
module tb_ws2812_stream_tx;
    localparam int CHANNELS = 4, DEPTH = 8, T0H = 8, T1H = 16, TBIT = 25, TRES = 1000;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] in_data;
    logic [1:0] in_chan;
    logic       in_last, in_valid, in_ready;
    logic [3:0] dout;
    logic       busy, underrun;

    ws2812_stream_tx #(.CHANNELS(CHANNELS), .DEPTH(DEPTH), .T0H_CYC(T0H), .T1H_CYC(T1H),
                       .TBIT_CYC(TBIT), .TRESET_CYC(TRES)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_chan(in_chan), .in_last(in_last),
        .in_valid(in_valid), .in_ready(in_ready), .dout(dout), .busy(busy), .underrun(underrun));

    always #5 clk = ~clk;

    typedef struct { logic [7:0] d; int ch; bit last; } byte_t;
    typedef struct { logic [7:0] d; int ch; int high; int lat; int bfall; } vec_t;

    int         checks = 0, errors = 0, acc_cnt = 0;
    byte_t      tx_q[$];
    logic [3:0] exp_q[$];
    logic [3:0] smp[1203];
    logic       bsmp[1203];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic push(input logic [7:0] d, input int ch, input bit last);
        int n = 0;
        @(negedge clk);
        in_data = d; in_chan = 2'(ch); in_last = last; in_valid = 1'b1;
        while (!in_ready && n < 5000) begin @(negedge clk); n++; end
        if (!in_ready) begin
            check("push_timeout", 0, 1);
            in_valid = 1'b0;
        end else begin
            @(posedge clk);
            acc_cnt++;
            #1 in_valid = 1'b0;
        end
    endtask

    // Ideal line waveform from the first rising edge: bit periods back to back, TRES low
    // after each frame, and IDLE+LOAD (2 cycles) before the next frame's first bit.
    task automatic build_expected();
        bit start = 1'b1, first = 1'b1;
        int ch = 0, th;
        exp_q.delete();
        foreach (tx_q[i]) begin
            if (start) begin
                if (!first) repeat (2) exp_q.push_back(4'd0);
                ch = tx_q[i].ch; start = 1'b0; first = 1'b0;
            end
            for (int b = 7; b >= 0; b--) begin
                th = tx_q[i].d[b] ? T1H : T0H;
                repeat (th) exp_q.push_back(4'(1 << ch));
                repeat (TBIT - th) exp_q.push_back(4'd0);
            end
            if (tx_q[i].last) begin
                repeat (TRES) exp_q.push_back(4'd0);
                start = 1'b1;
            end
        end
    endtask

    task automatic run_stream(input string name);
        int n, mism, first_bad;
        build_expected();
        fork
            begin
                foreach (tx_q[i]) push(tx_q[i].d, tx_q[i].ch, tx_q[i].last);
            end
            begin
                n = 0; mism = 0; first_bad = -1;
                @(negedge clk);
                while (dout == 4'd0 && n < 5000) begin @(negedge clk); n++; end
                check({name, "_start"}, int'(dout != 4'd0), 1);
                if (dout != 4'd0) begin
                    for (int i = 0; i < exp_q.size(); i++) begin
                        if (i > 0) @(negedge clk);
                        if (dout !== exp_q[i]) begin
                            if (first_bad < 0) first_bad = i;
                            mism++;
                        end
                    end
                    check($sformatf("%s_wave(first bad sample %0d)", name, first_bad), mism, 0);
                    check({name, "_busy_end"}, int'(busy), 0);
                end
            end
        join
    endtask

    initial begin
        vec_t vt[5];
        int   exp_runs[16];
        int   lat, hi, other, bfall, run, lvl, idx, n, fill;
        bit   ok;

        vt[0] = '{8'hA5, 2, 96, 3, 1202};
        vt[1] = '{8'hFF, 0, 128, 3, 1202};
        vt[2] = '{8'h00, 3, 64, 3, 1202};
        vt[3] = '{8'h80, 1, 72, 3, 1202};
        vt[4] = '{8'h3C, 3, 96, 3, 1202};
        exp_runs = '{16, 9, 8, 17, 16, 9, 8, 17, 8, 17, 16, 9, 8, 17, 16, 1009};

        rst = 1'b1; in_valid = 1'b0; in_data = 8'd0; in_chan = 2'd0; in_last = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_dout", int'(dout), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_ready", int'(in_ready), 0);
        check("rst_underrun", int'(underrun), 0);
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_rst", int'(in_ready), 1);

        // Single-byte frames: latency, high time on target, silence elsewhere, busy release
        for (int v = 0; v < 5; v++) begin
            push(vt[v].d, vt[v].ch, 1'b1);
            lat = -1; hi = 0; other = 0; bfall = -1;
            for (int k = 0; k < 1400; k++) begin
                @(negedge clk);
                if (dout[vt[v].ch] && lat < 0) lat = k;
                if (dout[vt[v].ch]) hi++;
                if ((dout & ~4'(1 << vt[v].ch)) != 4'd0) other++;
                if (!busy && bfall < 0) bfall = k;
            end
            check($sformatf("vec%0d_latency", v), lat, vt[v].lat);
            check($sformatf("vec%0d_high", v), hi, vt[v].high);
            check($sformatf("vec%0d_other", v), other, 0);
            check($sformatf("vec%0d_busy_fall", v), bfall, vt[v].bfall);
        end

        // 0xA5 on chan 2: exact high/low run lengths
        push(8'hA5, 2, 1'b1);
        for (int k = 0; k < 1203; k++) begin
            @(negedge clk);
            smp[k] = dout; bsmp[k] = busy;
        end
        idx = 3; ok = 1'b1;
        for (int r = 0; r < 16; r++) begin
            lvl = (r % 2 == 0) ? 1 : 0; run = 0;
            while (idx < 1203 && int'(smp[idx][2]) == lvl) begin run++; idx++; end
            check($sformatf("a5_run%0d", r), run, exp_runs[r]);
        end
        other = 0;
        for (int k = 0; k < 1203; k++) if ((smp[k] & 4'b1011) != 4'd0) other++;
        check("a5_other_lines", other, 0);
        check("a5_busy_before_end", int'(bsmp[1201]), 1);
        check("a5_busy_end", int'(bsmp[1202]), 0);

        tx_q.delete();
        tx_q.push_back('{8'h12, 0, 1'b0});
        tx_q.push_back('{8'hF0, 0, 1'b0});
        tx_q.push_back('{8'h0F, 0, 1'b1});
        run_stream("b2b3");

        tx_q.delete();
        tx_q.push_back('{8'h81, 1, 1'b0});
        tx_q.push_back('{8'h7E, 3, 1'b0});
        tx_q.push_back('{8'hC3, 3, 1'b1});
        tx_q.push_back('{8'h55, 3, 1'b1});
        run_stream("chan_latch");

        // FIFO fill: first byte is popped at once, then exactly DEPTH more fit
        tx_q.delete();
        tx_q.push_back('{8'hE7, 1, 1'b0});
        for (int i = 1; i <= 12; i++) tx_q.push_back('{8'(i * 19), 2, i == 12});
        acc_cnt = 0; fill = -1;
        fork
            run_stream("fill");
            begin
                n = 0;
                while (acc_cnt < 1 && n < 100) begin @(negedge clk); n++; end
                n = 0;
                @(negedge clk);
                while (in_ready && n < 500) begin @(negedge clk); n++; end
                fill = acc_cnt - 1;
            end
        join
        check("fill_depth", fill, DEPTH);

        for (int f = 0; f < 4; f++) begin
            tx_q.delete();
            n = $urandom_range(1, 3);
            for (int b = 0; b < n; b++)
                tx_q.push_back('{8'($urandom), int'($urandom_range(0, 3)), b == n - 1});
            run_stream($sformatf("rand%0d", f));
        end
        check("no_underrun", int'(underrun), 0);

        // Stall: non-last byte with nothing behind it
        push(8'h5A, 0, 1'b0);
        repeat (1300) @(negedge clk);
`ifdef WS2812_UNDERRUN_ABORT_EN
        check("stall_underrun", int'(underrun), 1);
        check("stall_busy", int'(busy), 0);
`else
        check("stall_underrun", int'(underrun), 0);
        check("stall_busy", int'(busy), 1);
`endif
        check("stall_dout", int'(dout), 0);
        push(8'hC3, 2, 1'b1);
        n = 0;
        while (busy && n < 3000) begin @(negedge clk); n++; end
        check("stall_recover_busy", int'(busy), 0);
        check("stall_recover_underrun", int'(underrun), 0);

        // Reset during the high phase of bit 3
        push(8'hFF, 1, 1'b1);
        n = 0;
        @(negedge clk);
        while (!dout[1] && n < 100) begin @(negedge clk); n++; end
        repeat (80) @(negedge clk);
        check("midbit_high", int'(dout[1]), 1);
        rst = 1'b1;
        #1;
        check("midbit_rst_dout", int'(dout), 0);
        check("midbit_rst_ready", int'(in_ready), 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("midbit_ready_after", int'(in_ready), 1);
        other = 0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (dout != 4'd0 || busy) other++;
        end
        check("midbit_residual", other, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
